// File: rtl/level_mux_pkg.sv
// Shared types and constants for the level bitmap selector and for game-control,
// which uses the LEVEL_* constants to drive levelCode.
package level_mux_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      BLANK   = 2'd2
   } lvl_sw_state_t;

   localparam int LEVEL_ONE = 0;
   localparam int LEVEL_TWO = 1;

   // Taking the code as a 32-bit value keeps the range check meaningful even when
   // NUM_LEVELS is a power of two and every encodable code is legal.
   function automatic logic code_ok(input int code, input int num_levels);
      return (code >= 0) && (code < num_levels);
   endfunction

endpackage

// File: rtl/level_switch_fsm.sv
// Level switch controller: holds the displayed level and defers every change to a
// frame boundary, optionally inserting full blank frames before the new level shows.
module level_switch_fsm
   import level_mux_pkg::*;
#(
   parameter  int NUM_LEVELS   = 4,
   parameter  int BLANK_FRAMES = 2,
   parameter  int RESET_LEVEL  = 0,
   localparam int LVL_W        = $clog2(NUM_LEVELS),
   localparam int CNT_W        = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              startOfFrame,
   input  logic              levelCodeValid,
   input  logic [LVL_W-1:0]  levelCode,
   output logic [LVL_W-1:0]  activeLevel,
   output logic              levelChanged,
   output lvl_sw_state_t     state_o
);

   lvl_sw_state_t    state_q,   state_d;
   logic [LVL_W-1:0] target_q,  target_d;
   logic [LVL_W-1:0] active_q,  active_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             changed_q, changed_d;

   logic             req_ok;
   logic             req_same;
   logic [LVL_W-1:0] next_level;

   assign req_ok   = levelCodeValid && code_ok(int'(levelCode), NUM_LEVELS);
   assign req_same = req_ok && (levelCode == active_q);
   // A request arriving together with startOfFrame wins over the stored target.
   assign next_level = req_ok ? levelCode : target_q;

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      active_d  = active_q;
      cnt_d     = cnt_q;
      changed_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_ok && !req_same) begin
               target_d = levelCode;
               state_d  = PENDING;
            end
         end
         PENDING: begin
            if (req_ok) begin
               target_d = levelCode;
            end
            if (req_same) begin
               state_d = IDLE;
            end else if (startOfFrame) begin
               if (BLANK_FRAMES > 0) begin
                  state_d = BLANK;
                  cnt_d   = '0;
               end else begin
                  active_d  = next_level;
                  changed_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         BLANK: begin
            if (req_ok) begin
               target_d = levelCode;
            end
            if (startOfFrame) begin
               if (cnt_q == CNT_W'(BLANK_FRAMES - 1)) begin
                  active_d  = next_level;
                  changed_d = (next_level != active_q);
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= IDLE;
         target_q  <= LVL_W'(RESET_LEVEL);
         active_q  <= LVL_W'(RESET_LEVEL);
         cnt_q     <= '0;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         active_q  <= active_d;
         cnt_q     <= cnt_d;
         changed_q <= changed_d;
      end
   end

   assign activeLevel  = active_q;
   assign levelChanged = changed_q;
   assign state_o      = state_q;

endmodule

// File: rtl/level_bitmap_mux.sv
// Registered selector that forwards one level's drawing request and colour into the
// display-priority chain, substituting a blank colour while a switch is blanking.
module level_bitmap_mux
   import level_mux_pkg::*;
#(
   parameter  int               NUM_LEVELS   = 4,
   parameter  int               RGB_W        = 8,
   parameter  int               BLANK_FRAMES = 2,
   parameter  logic [RGB_W-1:0] BLANK_RGB    = '0,
   parameter  int               RESET_LEVEL  = 0,
   localparam int               LVL_W        = $clog2(NUM_LEVELS)
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic                        startOfFrame,
   input  logic                        levelCodeValid,
   input  logic [LVL_W-1:0]            levelCode,
   input  logic [NUM_LEVELS-1:0]       drawingRequest,
   input  logic [NUM_LEVELS*RGB_W-1:0] RGB,
   output logic                        drawingRequest_out,
   output logic [RGB_W-1:0]            RGBout,
   output logic [LVL_W-1:0]            activeLevel,
   output logic                        switchBusy,
   output logic                        levelChanged
);

   lvl_sw_state_t    sw_state;
   logic             sel_dr;
   logic [RGB_W-1:0] sel_rgb;
   logic             dr_q,  dr_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;

   level_switch_fsm #(
      .NUM_LEVELS   (NUM_LEVELS),
      .BLANK_FRAMES (BLANK_FRAMES),
      .RESET_LEVEL  (RESET_LEVEL)
   ) u_fsm (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .levelCodeValid (levelCodeValid),
      .levelCode      (levelCode),
      .activeLevel    (activeLevel),
      .levelChanged   (levelChanged),
      .state_o        (sw_state)
   );

   always_comb begin
      sel_dr  = 1'b0;
      sel_rgb = '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         if (activeLevel == LVL_W'(i)) begin
            sel_dr  = drawingRequest[i];
            sel_rgb = RGB[i*RGB_W +: RGB_W];
         end
      end
   end

   // Blank frames still claim the pixel so lower-priority objects cannot show through.
   always_comb begin
      if (sw_state == BLANK) begin
         dr_d  = 1'b1;
         rgb_d = BLANK_RGB;
      end else begin
         dr_d  = sel_dr;
         rgb_d = sel_rgb;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         dr_q  <= 1'b0;
         rgb_q <= '0;
      end else begin
         dr_q  <= dr_d;
         rgb_q <= rgb_d;
      end
   end

   assign drawingRequest_out = dr_q;
   assign RGBout             = rgb_q;
   assign switchBusy         = (sw_state != IDLE);

endmodule

// File: doc/level_bitmap_mux.md
Name: level_bitmap_mux

Overview:
- Parametrised N-level bitmap selector: picks one of NUM_LEVELS drawing-request/RGB pairs and drives a single registered pair into the display-priority chain.
- Level changes are sticky and are applied only on frame boundaries, after a configurable number of full-screen blank frames, so partial-frame tearing cannot occur.
- Sits between the per-level bitmap generators and the VGA object mux; game-control drives levelCode.

Parameters:
NUM_LEVELS, 4, number of level channels (>=2)
RGB_W, 8, colour width per channel
LVL_W, $clog2(NUM_LEVELS), level index width (derived, not overridden)
BLANK_FRAMES, 2, full frames of blank output inserted on a level switch (0 = switch directly at the next frame start)
BLANK_RGB, 8'h00, colour driven during blank frames
RESET_LEVEL, 0, active level after reset

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
levelCodeValid  in  1  levelCode is a request this cycle
levelCode  in  LVL_W  requested level index
drawingRequest  in  NUM_LEVELS  per-level drawing request; bit i belongs to level i
RGB  in  NUM_LEVELS*RGB_W  packed colours; level i occupies [i*RGB_W +: RGB_W]
drawingRequest_out  out  1  selected drawing request (registered)
RGBout  out  RGB_W  selected colour (registered)
activeLevel  out  LVL_W  level currently displayed
switchBusy  out  1  high while a switch is pending or blanking
levelChanged  out  1  one-cycle pulse when activeLevel updates

Behaviour:
- Reset (async, any state): RGBout=0, drawingRequest_out=0, activeLevel=RESET_LEVEL, switchBusy=0, levelChanged=0, FSM=IDLE, targetLevel=RESET_LEVEL, blankCnt=0. Reset asserted mid-switch aborts the switch.
- Datapath, one-cycle latency: at each edge, if FSM=BLANK then drawingRequest_out<=1, RGBout<=BLANK_RGB; otherwise drawingRequest_out<=drawingRequest[activeLevel], RGBout<=RGB slice of activeLevel. Both use the pre-edge activeLevel and state.
- Request acceptance: a request is levelCodeValid=1 with levelCode<NUM_LEVELS. Out-of-range codes are ignored entirely, and the current level is held.
- FSM states: IDLE, PENDING, BLANK.
- IDLE:
  - Request with code != activeLevel: targetLevel<=code, go to PENDING.
  - Request with code == activeLevel: no action.
- PENDING (waits for a frame boundary):
  - A new request overwrites targetLevel.
  - A request equal to activeLevel cancels the switch and returns to IDLE.
  - On startOfFrame with BLANK_FRAMES>0: go to BLANK, blankCnt<=0.
  - On startOfFrame with BLANK_FRAMES=0: activeLevel<=targetLevel, levelChanged<=1, go to IDLE.
  - Request and startOfFrame in the same cycle: the request's code is used as the target for that transition. If that code equals activeLevel, this is a cancel.
- BLANK:
  - Requests update targetLevel; a request equal to activeLevel is legal here.
  - On startOfFrame with blankCnt<BLANK_FRAMES-1: blankCnt++.
  - On startOfFrame with blankCnt==BLANK_FRAMES-1: activeLevel<=targetLevel (including a same-cycle request), go to IDLE.
  - levelChanged<=1 only if the new value differs from the old activeLevel.
- switchBusy = (FSM != IDLE), driven combinationally from the state register.
- levelChanged is high for exactly one cycle, never two in a row.
- The first non-blank pixel of the new level appears on RGBout one cycle after the activeLevel update.
- blankCnt width: $clog2(BLANK_FRAMES+1); no wrap is possible.

Decomposition:
- Shared package level_mux_pkg holds:
  - typedef enum logic [1:0] {IDLE, PENDING, BLANK} lvl_sw_state_t
  - constants LEVEL_ONE=0, LEVEL_TWO=1, used by game-control.
- One sub-module, level_switch_fsm: owns state, targetLevel, blankCnt, activeLevel and levelChanged.
- The top level holds only the registered output mux.

Test Plan:
- Reset check (NUM_LEVELS=4, RGB slices 8'h11/22/33/44, all drawingRequest=1):
  - Release reset with levelCodeValid=0 -> RGBout=8'h11 one cycle later, activeLevel=0, switchBusy=0.
- Switch with blanking (BLANK_FRAMES=2):
  - Request levelCode=2 mid-frame -> switchBusy=1 next cycle, output stays 8'h11 until the next startOfFrame.
  - Then BLANK_RGB 8'h00 with drawingRequest_out=1 for exactly 2 frames.
  - At the third startOfFrame: activeLevel=2 and levelChanged pulses once; RGBout=8'h33 the following cycle.
- Cancel: in PENDING, request levelCode=0 (current level) before startOfFrame -> FSM returns to IDLE, no blank frames, levelChanged never asserts.
- Out-of-range request (NUM_LEVELS=3, levelCode=3, valid=1) -> no state change, switchBusy stays 0, output unchanged.
- Retarget during BLANK: request 1 then request 3 during blanking -> activeLevel ends at 3; same-cycle request at the final startOfFrame takes priority.
- Reset mid-BLANK: assert resetN=0 -> outputs 0 immediately; after release, activeLevel=RESET_LEVEL and FSM=IDLE.
- BLANK_FRAMES=0: request 1, then startOfFrame -> activeLevel=1 on the next edge with no blank output.
